// File: rtl/axis_spi_reg_bridge.sv
// SPI register bridge: turns cmd/addr/data byte frames from the SPI slave into register-bus accesses.
// Latency byte->request 2 clk, reg_ack->response 1 clk; input tready stays low while a response is pending.
module axis_spi_reg_bridge #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    input  logic                  input_axis_tlast,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    output logic                  reg_wr_en,
    output logic                  reg_rd_en,
    input  logic [DATA_WIDTH-1:0] reg_rd_data,
    input  logic                  reg_ack,
    output logic                  busy,
    output logic                  error
);
    localparam logic [DATA_WIDTH-1:0] CMD_WRITE = DATA_WIDTH'(8'h02);
    localparam logic [DATA_WIDTH-1:0] CMD_READ  = DATA_WIDTH'(8'h03);
    localparam logic [15:0]           TMO_LAST  = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_CMD, S_ADDR, S_WDATA, S_RDATA, S_WREQ, S_RREQ, S_OUT, S_DISCARD
    } state_t;

    state_t                state_q;
    state_t                ret_q;
    logic                  in_rdy_q;
    logic                  out_vld_q;
    logic                  wr_en_q;
    logic                  rd_en_q;
    logic                  is_wr_q;
    logic                  last_q;
    logic                  error_q;
    logic [DATA_WIDTH-1:0] out_dat_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [15:0]           cnt_q;
    logic                  in_hs;
    logic                  req_done;

    assign in_hs    = input_axis_tvalid & in_rdy_q;
    // an ack landing in the expiry cycle still wins over the timeout
    assign req_done = reg_ack | (cnt_q == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_CMD;
            ret_q     <= S_ADDR;
            in_rdy_q  <= 1'b0;
            out_vld_q <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            is_wr_q   <= 1'b0;
            last_q    <= 1'b0;
            error_q   <= 1'b0;
            out_dat_q <= '0;
            data_q    <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
        end else begin
            error_q <= 1'b0;
            case (state_q)
                S_CMD: begin
                    in_rdy_q <= 1'b1;
                    if (in_hs) begin
                        in_rdy_q <= 1'b0;
                        if (!input_axis_tlast) begin
                            if (input_axis_tdata == CMD_WRITE || input_axis_tdata == CMD_READ) begin
                                is_wr_q   <= (input_axis_tdata == CMD_WRITE);
                                out_dat_q <= '0;
                                out_vld_q <= 1'b1;
                                ret_q     <= S_ADDR;
                                state_q   <= S_OUT;
                            end else begin
                                in_rdy_q <= 1'b1;
                                error_q  <= 1'b1;
                                state_q  <= S_DISCARD;
                            end
                        end
                    end
                end
                S_ADDR: if (in_hs) begin
                    in_rdy_q <= 1'b0;
                    addr_q   <= input_axis_tdata[ADDR_WIDTH-1:0];
                    if (input_axis_tlast) begin
                        state_q <= S_CMD;
                    end else if (is_wr_q) begin
                        out_dat_q <= '0;
                        out_vld_q <= 1'b1;
                        ret_q     <= S_WDATA;
                        state_q   <= S_OUT;
                    end else begin
                        state_q <= S_RREQ;
                    end
                end
                S_WDATA: if (in_hs) begin
                    in_rdy_q <= 1'b0;
                    data_q   <= input_axis_tdata;
                    last_q   <= input_axis_tlast;
                    state_q  <= S_WREQ;
                end
                S_RDATA: if (in_hs) begin
                    in_rdy_q <= 1'b0;
                    state_q  <= input_axis_tlast ? S_CMD : S_RREQ;
                end
                S_WREQ, S_RREQ: begin
                    if (!wr_en_q && !rd_en_q) begin
                        wr_en_q <= (state_q == S_WREQ);
                        rd_en_q <= (state_q == S_RREQ);
                        cnt_q   <= '0;
                    end else if (req_done) begin
                        wr_en_q <= 1'b0;
                        rd_en_q <= 1'b0;
                        addr_q  <= addr_q + ADDR_WIDTH'(1);
                        error_q <= !reg_ack;
                        if (state_q == S_RREQ) begin
                            out_dat_q <= reg_ack ? reg_rd_data : '1;
                            out_vld_q <= 1'b1;
                            ret_q     <= S_RDATA;
                            state_q   <= S_OUT;
                        end else if (last_q) begin
                            state_q <= S_CMD;
                        end else begin
                            out_dat_q <= data_q;
                            out_vld_q <= 1'b1;
                            ret_q     <= S_WDATA;
                            state_q   <= S_OUT;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_OUT: begin
                    if (output_axis_tready) begin
                        out_vld_q <= 1'b0;
                        in_rdy_q  <= 1'b1;
                        state_q   <= ret_q;
                    end else if (input_axis_tvalid && input_axis_tlast) begin
                        // frame ended before the response shifted out: withdraw it
                        out_vld_q <= 1'b0;
                        error_q   <= 1'b1;
                        state_q   <= S_CMD;
                    end
                end
                S_DISCARD: if (in_hs && input_axis_tlast) begin
                    in_rdy_q <= 1'b0;
                    state_q  <= S_CMD;
                end
                default: state_q <= S_CMD;
            endcase
        end
    end

    assign input_axis_tready  = in_rdy_q;
    assign output_axis_tdata  = out_dat_q;
    assign output_axis_tvalid = out_vld_q;
    assign reg_addr           = addr_q;
    assign reg_wr_data        = data_q;
    assign reg_wr_en          = wr_en_q;
    assign reg_rd_en          = rd_en_q;
    assign busy               = (state_q != S_CMD);
    assign error              = error_q;

endmodule
